trace_drain_fifo: RTL and testbench

TRACE_DRAIN_FIFO -- requirements
Module: trace_drain_fifo

---
 rtl/trace_drain_fifo.sv | 95 +++++++++
 tb/tb_trace_drain_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/trace_drain_fifo.sv
// Trace drain FIFO: buffers trace records tagged with a strobe sequence number,
// drops records on overflow and keeps a sticky overflow flag and a saturating drop count.
module trace_drain_fifo #(
  parameter int unsigned TRACE_WIDTH = 128,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     trace_ready_i,
  input  logic [TRACE_WIDTH-1:0]   trace_i,
  input  logic                     clear_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [TRACE_WIDTH-1:0]   out_data_o,
  output logic [CNT_WIDTH-1:0]     out_seq_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  output logic [CNT_WIDTH-1:0]     drop_count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] L_FULL = LW'(DEPTH);

  logic [TRACE_WIDTH-1:0] r_data_mem [DEPTH];
  logic [CNT_WIDTH-1:0]   r_seq_mem  [DEPTH];
  logic [AW-1:0]          r_wptr;
  logic [AW-1:0]          r_rptr;
  logic [LW-1:0]          r_level;
  logic [CNT_WIDTH-1:0]   r_seq;
  logic                   r_overflow;
  logic [CNT_WIDTH-1:0]   r_drop_cnt;

  logic w_pop;
  logic w_push;
  logic w_full;
  logic w_drop;

  // Pop depends only on registered occupancy, so an empty FIFO never bypasses.
  always_comb begin
    w_full = (r_level == L_FULL);
    w_pop  = (r_level != '0) && out_ready_i;
    w_push = trace_ready_i && (!w_full || w_pop);
    w_drop = trace_ready_i && w_full && !w_pop;
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_data_mem[r_wptr] <= trace_i;
      r_seq_mem[r_wptr]  <= r_seq;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_seq      <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (trace_ready_i) r_seq <= r_seq + CNT_WIDTH'(1);
      // A drop in the same cycle as clear_i wins and restarts the count at one.
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (clear_i)
          r_drop_cnt <= CNT_WIDTH'(1);
        else if (r_drop_cnt != '1)
          r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
      end else if (clear_i) begin
        r_overflow <= 1'b0;
        r_drop_cnt <= '0;
      end
    end
  end

  always_comb begin
    out_valid_o  = (r_level != '0);
    out_data_o   = r_data_mem[r_rptr];
    out_seq_o    = r_seq_mem[r_rptr];
    level_o      = r_level;
    overflow_o   = r_overflow;
    drop_count_o = r_drop_cnt;
  end

endmodule

// File: tb/tb_trace_drain_fifo.sv
// Bench for trace_drain_fifo: directed scenarios plus random traffic against a queue model,
// and a narrow-counter instance for drop-count saturation.
module tb_trace_drain_fifo;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: DEPTH 16, CNT_WIDTH 16
  logic        rst = 1'b1, tr = 1'b0, clr = 1'b0, ordy = 1'b0;
  logic [31:0] tdata = '0;
  logic        valid, ovf;
  logic [31:0] odata;
  logic [15:0] oseq, drop;
  logic [4:0]  level;

  trace_drain_fifo #(.TRACE_WIDTH(32), .DEPTH(16), .CNT_WIDTH(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .trace_ready_i(tr), .trace_i(tdata), .clear_i(clr),
    .out_valid_o(valid), .out_ready_i(ordy), .out_data_o(odata), .out_seq_o(oseq),
    .level_o(level), .overflow_o(ovf), .drop_count_o(drop)
  );

  // Saturation instance: DEPTH 4, CNT_WIDTH 4
  logic       s_rst = 1'b1, s_tr = 1'b0, s_clr = 1'b0, s_ordy = 1'b0;
  logic [7:0] s_tdata = '0;
  logic       s_valid, s_ovf;
  logic [7:0] s_odata;
  logic [3:0] s_oseq, s_drop;
  logic [2:0] s_level;

  trace_drain_fifo #(.TRACE_WIDTH(8), .DEPTH(4), .CNT_WIDTH(4)) u_sat (
    .clk_i(clk), .rst_i(s_rst), .trace_ready_i(s_tr), .trace_i(s_tdata), .clear_i(s_clr),
    .out_valid_o(s_valid), .out_ready_i(s_ordy), .out_data_o(s_odata), .out_seq_o(s_oseq),
    .level_o(s_level), .overflow_o(s_ovf), .drop_count_o(s_drop)
  );

  int checks = 0;
  int errors = 0;

  // Reference model for the main instance
  logic [47:0] q[$];
  logic [15:0] m_seq = '0;
  logic        m_ovf = 1'b0;
  int          m_drop = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    int n;
    bit pop, push;
    n    = q.size();
    pop  = (n != 0) && ordy;
    push = tr && ((n < 16) || pop);
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      m_seq  = '0;
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back({m_seq, tdata});
      if (tr && !push) begin
        m_ovf  = 1'b1;
        m_drop = clr ? 1 : ((m_drop == 65535) ? m_drop : m_drop + 1);
      end else if (clr) begin
        m_ovf  = 1'b0;
        m_drop = 0;
      end
      if (tr) m_seq = m_seq + 16'd1;
    end
    check("level", 64'(level), 64'(q.size()));
    check("valid", 64'(valid), 64'(q.size() != 0));
    check("overflow", 64'(ovf), 64'(m_ovf));
    check("drop_count", 64'(drop), 64'(m_drop));
    if (q.size() != 0) begin
      check("head_data", 64'(odata), 64'(q[0][31:0]));
      check("head_seq", 64'(oseq), 64'(q[0][47:32]));
    end
  endtask

  task automatic drive(input logic t, input logic r, input logic c);
    tr    = t;
    ordy  = r;
    clr   = c;
    tdata = $urandom;
  endtask

  initial begin
    logic [31:0] rec_a;

    // Reset
    rst = 1'b1; drive(0, 0, 0);
    cycle(); cycle();
    check("rst_level", 64'(level), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    rst = 1'b0;

    // Single record
    drive(1, 0, 0);
    rec_a = tdata;
    cycle();
    check("single_valid", 64'(valid), 64'd1);
    check("single_data", 64'(odata), 64'(rec_a));
    check("single_seq", 64'(oseq), 64'd0);
    check("single_level", 64'(level), 64'd1);

    // Fill to DEPTH, then one dropped strobe
    for (int i = 0; i < 15; i++) begin drive(1, 0, 0); cycle(); end
    check("fill_level", 64'(level), 64'd16);
    drive(1, 0, 0); cycle();
    check("drop_ovf", 64'(ovf), 64'd1);
    check("drop_cnt", 64'(drop), 64'd1);

    // Full with push and pop together
    drive(1, 1, 0); cycle();
    check("full_pp_level", 64'(level), 64'd16);
    check("full_pp_drop", 64'(drop), 64'd1);
    for (int i = 0; i < 15; i++) begin drive(0, 1, 0); cycle(); end
    check("gap_seq", 64'(oseq), 64'd17);
    drive(0, 1, 0); cycle();

    // Clear alone
    drive(0, 0, 1); cycle();
    check("clear_ovf", 64'(ovf), 64'd0);
    check("clear_drop", 64'(drop), 64'd0);

    // Empty FIFO, push and ready together: no bypass
    drive(1, 1, 0); cycle();
    check("nobypass_level", 64'(level), 64'd1);
    drive(0, 1, 0); cycle();

    // Backpressure stream of 8 records
    rst = 1'b1; drive(0, 0, 0); cycle(); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin drive(1, logic'(i % 2), 0); cycle(); end
    for (int i = 0; i < 10; i++) begin drive(0, logic'(i % 2), 0); cycle(); end
    check("bp_drained", 64'(level), 64'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0,
            (i < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0),
            $urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 149) == 0);
      cycle();
    end
    rst = 1'b0;

    // Reset with 5 records stored
    rst = 1'b1; drive(0, 0, 0); cycle(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin drive(1, 0, 0); cycle(); end
    check("pre_rst_level", 64'(level), 64'd5);
    rst = 1'b1; drive(1, 1, 1); cycle(); rst = 1'b0;
    check("mid_rst_level", 64'(level), 64'd0);
    check("mid_rst_valid", 64'(valid), 64'd0);
    drive(1, 0, 0); cycle();
    check("post_rst_seq", 64'(oseq), 64'd0);
    drive(0, 0, 0); cycle();

    // Saturation on the 4-bit counter instance
    s_rst = 1'b1; cycle(); s_rst = 1'b0;
    s_tr = 1'b1;
    for (int i = 0; i < 24; i++) begin s_tdata = 8'($urandom); cycle(); end
    check("sat_level", 64'(s_level), 64'd4);
    check("sat_ovf", 64'(s_ovf), 64'd1);
    check("sat_drop", 64'(s_drop), 64'd15);
    s_tr = 1'b0; s_clr = 1'b1; cycle();
    check("sat_clr_drop", 64'(s_drop), 64'd0);
    check("sat_clr_ovf", 64'(s_ovf), 64'd0);
    s_tr = 1'b1; s_clr = 1'b1; cycle();
    check("sat_clrdrop_drop", 64'(s_drop), 64'd1);
    check("sat_clrdrop_ovf", 64'(s_ovf), 64'd1);
    s_tr = 1'b0; s_clr = 1'b0; cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
